microwave_panel: RTL and testbench
==================================

# microwave_panel

Front-panel controller for the microwave range FSM. It accepts keypad events and composes a cook time, then launches the range through its `tin`/`r` inputs. While cooking it tracks the range's power output `p` to show remaining time, and it signals completion, abort and errors. It is the initiator side of the range's time/run interface and sits between the keypad scanner and the range.

## Interface
Parameters:
- `TW`, 4: width of time values; matches the range's `tin`.
- `TICKS_PER_UNIT`, 20: clock cycles per time unit for the `remain` countdown; must be ≥1.
- `PWR_TIMEOUT`, 4: cycles after the run pulse within which `pwr` must rise.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `key_valid`, in, 1: one-cycle strobe; `key_code` is valid while high.
- `key_code`, in, 4: 0–9 = digit, 10 = START, 11 = CANCEL, 12 = PLUS1, 13–15 = ignored.
- `door_open`, in, 1: level; high means the door is open.
- `pwr`, in, 1: the range's power output `p`.
- `tin`, out, TW: time value driven to the range.
- `r`, out, 1: run/stop strobe to the range.
- `remain`, out, TW: displayed time. Shows `set_time` in IDLE and the countdown in COOK.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when cooking ends normally.
- `err`, out, 1: one-cycle pulse on a rejected START or a power timeout.

## Operation
- Reset value of every output is 0 (`tin`, `r`, `remain`, `busy`, `done`, `err`). State resets to IDLE; `set_time`, the tick counter and the timeout counter reset to 0.
- Reset has priority over all other inputs in every state. A reset mid-cook drops `r`/`tin` to 0 at the next edge and does not send a stop strobe.
- All outputs are registered.
- States are IDLE, LAUNCH, WAIT_PWR, COOK and STOP.
- IDLE:
  - Digit d loads `set_time` = d.
  - PLUS1 sets `set_time` = min(`set_time`+1, 2^TW−1).
  - CANCEL clears `set_time`.
  - START with `set_time`≠0 and `door_open`=0 moves to LAUNCH.
  - START with `set_time`=0 or `door_open`=1 pulses `err` and the state stays IDLE.
- LAUNCH: drives `tin`=`set_time` and `r`=1 for exactly one cycle, then moves to WAIT_PWR.
- WAIT_PWR:
  - `tin`=0, `r`=0.
  - If `pwr`=1 within PWR_TIMEOUT cycles: load `remain`=`set_time`, clear the tick counter, move to COOK.
  - On timeout: pulse `err`, clear `set_time`, move to IDLE.
  - CANCEL or `door_open`: move to STOP.
- COOK:
  - The tick counter increments each cycle. When it reaches TICKS_PER_UNIT−1 it wraps to 0 and `remain` decrements, saturating at 0.
  - `pwr` falling to 0 pulses `done`, clears `remain` and `set_time`, and moves to IDLE.
  - CANCEL or `door_open`=1 moves to STOP.
  - If `pwr` falls in the same cycle as CANCEL or `door_open`, the `pwr` fall wins: `done` pulses and no stop strobe is sent.
- STOP:
  - Drives `r`=1 with `tin`=0 for one cycle; this is the range stop request.
  - Clears `remain` and `set_time`, then moves to IDLE. No `done` pulse.
- Keys other than CANCEL are ignored outside IDLE. Codes 13–15 are ignored everywhere.
- A key event and `door_open` in the same IDLE cycle: the key is processed; a START is rejected because of `door_open`.

## Timing
- A key accepted at edge k is reflected in `set_time`/`remain` after edge k+1.
- Launch sequence for START sampled at edge k:
  - `r`=1 and `tin`=`set_time` after edge k+1.
  - Both return to 0 after edge k+2.
  - `busy`=1 from after edge k+1.
- Power timeout window: `pwr` is sampled on the PWR_TIMEOUT edges following the run pulse. With `pwr` still 0 at the last of these, `err` pulses on the next cycle and `busy` drops with it.
- COOK countdown: first decrement TICKS_PER_UNIT cycles after COOK entry. With `pwr` held, `remain` reaches 0 after `set_time`×TICKS_PER_UNIT cycles and then holds.
- `done` and `err` are high for exactly one cycle and never high together.

## Test plan
- Keys 7 then START, door closed, `pwr` rises 2 cycles after `r`. Required:
  - One `r` pulse carrying `tin`=7.
  - `remain` goes 7→6 after TICKS_PER_UNIT cycles.
  - `pwr` falls → one-cycle `done` pulse, `busy`=0, `remain`=0.
- START with `set_time`=0, and START with `door_open`=1 and digit 4 loaded. Each case: one `err` pulse, `r` stays 0, `remain` still shows 0 / 4 respectively.
- Key 9, then PLUS1 ×8. Required: `set_time` saturates at 15; `remain`=15 in IDLE.
- Key 5, START, `pwr` held 0. Required: one `r` pulse, `err` pulses exactly PWR_TIMEOUT+1 cycles after the pulse, state returns to IDLE with `set_time`=0.
- In COOK with `remain`=3:
  - Assert `door_open`. Required: one cycle of `r`=1 with `tin`=0, `remain`=0, no `done`.
  - Repeat with CANCEL asserted in the same cycle `pwr` falls. Required: `done` pulses and no stop strobe is sent.
- Assert `rst` mid-COOK. Required: all outputs 0 on the next cycle, state IDLE, and a subsequent 3/START cycle runs normally.

Source files
------------

// File: rtl/microwave_panel.sv
// Front-panel controller: composes a cook time from keypad events,
// launches the range over tin/r and tracks its power output.
module microwave_panel #(
  parameter int TW             = 4,
  parameter int TICKS_PER_UNIT = 20,
  parameter int PWR_TIMEOUT    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          door_open,
  input  logic          pwr,
  output logic [TW-1:0] tin,
  output logic          r,
  output logic [TW-1:0] remain,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(TICKS_PER_UNIT + 1);
  localparam int OW = $clog2(PWR_TIMEOUT + 1);
  localparam logic [TW-1:0] MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_PWR,
    COOK,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] set_time, set_n;
  logic [TW-1:0] rem_n, tin_n;
  logic [CW-1:0] tick, tick_n;
  logic [OW-1:0] wcnt, wcnt_n;
  logic          tmo, tmo_n;
  logic          r_n, busy_n, done_n, err_n;
  logic          cancel, stop_req;

  assign cancel   = key_valid && (key_code == 4'd11);
  assign stop_req = cancel || door_open;

  always_comb begin
    state_n = state;
    set_n   = set_time;
    rem_n   = remain;
    tick_n  = tick;
    wcnt_n  = wcnt;
    tmo_n   = 1'b0;
    tin_n   = '0;
    r_n     = 1'b0;
    busy_n  = (state != IDLE);
    done_n  = 1'b0;
    // a power timeout is reported one cycle late, together with busy falling
    err_n   = tmo;
    unique case (state)
      IDLE: begin
        rem_n = set_time;
        if (key_valid) begin
          unique case (1'b1)
            key_code <= 4'd9: set_n = TW'(key_code);
            key_code == 4'd12: begin
              if (set_time != MAX) set_n = set_time + TW'(1);
            end
            cancel: set_n = '0;
            key_code == 4'd10: begin
              if (set_time == '0 || door_open) err_n = 1'b1;
              else state_n = LAUNCH;
            end
            default: ;
          endcase
        end
      end
      LAUNCH: begin
        tin_n   = set_time;
        r_n     = 1'b1;
        wcnt_n  = '0;
        state_n = WAIT_PWR;
      end
      WAIT_PWR: begin
        if (stop_req) begin
          state_n = STOP;
        end else if (pwr) begin
          rem_n   = set_time;
          tick_n  = '0;
          state_n = COOK;
        end else if (wcnt == OW'(PWR_TIMEOUT - 1)) begin
          tmo_n   = 1'b1;
          set_n   = '0;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + OW'(1);
        end
      end
      COOK: begin
        // a power drop outranks a concurrent stop request
        if (!pwr) begin
          done_n  = 1'b1;
          rem_n   = '0;
          set_n   = '0;
          state_n = IDLE;
        end else if (stop_req) begin
          state_n = STOP;
        end else if (tick == CW'(TICKS_PER_UNIT - 1)) begin
          tick_n = '0;
          if (remain != '0) rem_n = remain - TW'(1);
        end else begin
          tick_n = tick + CW'(1);
        end
      end
      STOP: begin
        r_n     = 1'b1;
        rem_n   = '0;
        set_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      set_time <= '0;
      tick     <= '0;
      wcnt     <= '0;
      tmo      <= 1'b0;
      tin      <= '0;
      r        <= 1'b0;
      remain   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      set_time <= set_n;
      tick     <= tick_n;
      wcnt     <= wcnt_n;
      tmo      <= tmo_n;
      tin      <= tin_n;
      r        <= r_n;
      remain   <= rem_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_microwave_panel.sv
// Directed/randomized bench for microwave_panel with a
// behavioural model of the set time and countdown.
module tb_microwave_panel;

  localparam int TW = 4;
  localparam int T  = 20;
  localparam int PT = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          door_open;
  logic          pwr;
  logic [TW-1:0] tin;
  logic          r;
  logic [TW-1:0] remain;
  logic          busy;
  logic          done;
  logic          err;

  microwave_panel #(
    .TW(TW),
    .TICKS_PER_UNIT(T),
    .PWR_TIMEOUT(PT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .door_open(door_open),
    .pwr(pwr),
    .tin(tin),
    .r(r),
    .remain(remain),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int r_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int r_cyc = 0, err_cyc = 0;
  int last_tin = 0;
  logic err_busy = 1'b0;
  int set_m = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (r) begin
      r_cnt++;
      r_cyc = cyc;
      last_tin = int'(tin);
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
      err_busy = busy;
    end
    if (done && err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    step();
    key_valid = 1'b0;
  endtask

  // keypad rules in IDLE, independent of any FSM encoding
  function automatic int model_key(input int cur, input int c);
    if (c <= 9) return c & TMAX;
    if (c == 11) return 0;
    if (c == 12) return (cur + 1 > TMAX) ? TMAX : cur + 1;
    return cur;
  endfunction

  function automatic int model_remain(input int t0, input int n);
    int v;
    v = t0 - n / T;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic key_idle(input int c, input string tag);
    press(4'(c));
    set_m = model_key(set_m, c);
    step();
    check(tag, 32'(remain), 32'(set_m));
  endtask

  task automatic launch_cook(input int t);
    key_idle(t, "cook_set");
    press(4'd10);
    step();
    step();
    pwr = 1'b1;
    step();
    check("cook_entry_remain", 32'(remain), 32'(t));
  endtask

  initial begin
    int r0, d0, e0, d, n, c, t;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = '0;
    door_open = 1'b0;
    pwr = 1'b0;
    repeat (3) step();
    check("rst_tin", 32'(tin), 0);
    check("rst_r", 32'(r), 0);
    check("rst_remain", 32'(remain), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    step();

    // random IDLE key traffic (no START)
    for (int i = 0; i < 14; i++) begin
      c = int'($urandom_range(0, 15));
      if (c == 10) c = 12;
      door_open = 1'(($urandom_range(0, 3) == 0));
      key_idle(c, "rand_key");
    end
    door_open = 1'b0;
    check("rand_busy", 32'(busy), 0);

    // normal cook of 7
    key_idle(7, "k7");
    r0 = r_cnt; d0 = done_cnt; e0 = err_cnt;
    press(4'd10);
    step();
    check("launch_r", 32'(r), 1);
    check("launch_tin", 32'(tin), 7);
    check("launch_busy", 32'(busy), 1);
    step();
    check("launch_r_low", 32'(r), 0);
    check("launch_tin_low", 32'(tin), 0);
    d = int'($urandom_range(0, PT - 2));
    repeat (d) step();
    pwr = 1'b1;
    step();
    check("cook7_entry", 32'(remain), 7);
    n = T + int'($urandom_range(0, T));
    for (int i = 1; i <= n; i++) begin
      step();
      check("cook7_remain", 32'(remain), 32'(model_remain(7, i)));
    end
    pwr = 1'b0;
    step();
    check("cook7_done", 32'(done), 1);
    check("cook7_clr", 32'(remain), 0);
    step();
    check("cook7_done_low", 32'(done), 0);
    check("cook7_busy", 32'(busy), 0);
    check("cook7_rpulses", 32'(r_cnt - r0), 1);
    check("cook7_dones", 32'(done_cnt - d0), 1);
    check("cook7_errs", 32'(err_cnt - e0), 0);
    set_m = 0;

    // rejected START: zero time, then door open with 4
    key_idle(11, "cancel");
    r0 = r_cnt; e0 = err_cnt;
    press(4'd10);
    repeat (3) step();
    check("rej0_err", 32'(err_cnt - e0), 1);
    check("rej0_r", 32'(r_cnt - r0), 0);
    check("rej0_remain", 32'(remain), 0);
    door_open = 1'b1;
    key_idle(4, "door_k4");
    r0 = r_cnt; e0 = err_cnt;
    press(4'd10);
    repeat (3) step();
    check("rejd_err", 32'(err_cnt - e0), 1);
    check("rejd_r", 32'(r_cnt - r0), 0);
    check("rejd_remain", 32'(remain), 4);
    check("rejd_busy", 32'(busy), 0);
    door_open = 1'b0;

    // PLUS1 saturation
    key_idle(9, "k9");
    for (int i = 0; i < 8; i++) key_idle(12, "plus1");
    check("sat_remain", 32'(remain), 32'(TMAX));

    // power timeout
    key_idle(5, "k5");
    r0 = r_cnt; e0 = err_cnt;
    press(4'd10);
    repeat (PT + 4) step();
    set_m = 0;
    check("tmo_rpulses", 32'(r_cnt - r0), 1);
    check("tmo_errs", 32'(err_cnt - e0), 1);
    check("tmo_delay", 32'(err_cyc - r_cyc), 32'(PT + 1));
    check("tmo_busy_at_err", 32'(err_busy), 0);
    check("tmo_remain", 32'(remain), 0);

    // door opens mid-cook with 3 left
    launch_cook(3);
    r0 = r_cnt; d0 = done_cnt;
    door_open = 1'b1;
    step();
    step();
    check("stop_r", 32'(r), 1);
    check("stop_tin", 32'(tin), 0);
    check("stop_remain", 32'(remain), 0);
    pwr = 1'b0;
    door_open = 1'b0;
    step();
    check("stop_r_low", 32'(r), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_rpulses", 32'(r_cnt - r0), 1);
    check("stop_dones", 32'(done_cnt - d0), 0);
    set_m = 0;

    // CANCEL coincides with power drop
    launch_cook(3);
    r0 = r_cnt; d0 = done_cnt;
    key_valid = 1'b1;
    key_code = 4'd11;
    pwr = 1'b0;
    step();
    key_valid = 1'b0;
    check("race_done", 32'(done), 1);
    check("race_remain", 32'(remain), 0);
    repeat (2) step();
    check("race_rpulses", 32'(r_cnt - r0), 0);
    check("race_dones", 32'(done_cnt - d0), 1);
    check("race_busy", 32'(busy), 0);
    set_m = 0;

    // reset mid-cook, then a normal 3-unit run
    t = int'($urandom_range(1, 9));
    launch_cook(t);
    repeat (int'($urandom_range(1, 2 * T))) step();
    rst = 1'b1;
    step();
    check("mrst_tin", 32'(tin), 0);
    check("mrst_r", 32'(r), 0);
    check("mrst_remain", 32'(remain), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_err", 32'(err), 0);
    rst = 1'b0;
    pwr = 1'b0;
    set_m = 0;
    step();
    key_idle(3, "post_k3");
    r0 = r_cnt; d0 = done_cnt;
    press(4'd10);
    step();
    check("post_r", 32'(r), 1);
    check("post_tin", 32'(tin), 3);
    step();
    pwr = 1'b1;
    step();
    repeat (T) step();
    check("post_remain", 32'(remain), 2);
    pwr = 1'b0;
    step();
    check("post_done", 32'(done), 1);
    step();
    check("post_rpulses", 32'(r_cnt - r0), 1);
    check("post_dones", 32'(done_cnt - d0), 1);
    check("done_err_overlap", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
